// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying a control field and payload between stages; one-cycle latency.
// SKID=0: single entry, in_ready combinational from out_ready. SKID=1: two-entry skid, registered in_ready, absorbs one entry after a stall.
module pipe_stage_reg #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           in_ent;
  entry_t           main_q, main_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  assign in_ent = {in_ctrl, in_data};

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
      } state_t;

      state_t state_q, state_d;
      entry_t skid_q, skid_d;
      logic   in_rdy_q, in_rdy_d;
      logic   in_xfer, out_xfer;

      assign out_valid = (state_q != EMPTY);
      assign in_ready  = in_rdy_q;
      assign in_xfer   = in_valid & in_rdy_q;
      assign out_xfer  = (state_q != EMPTY) & out_ready;

      // Skid always drains into main before main reloads from the input.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              main_d  = in_ent;
              state_d = BUSY;
            end
          end
          BUSY: begin
            if (in_xfer && out_xfer) begin
              main_d = in_ent;
            end else if (in_xfer) begin
              skid_d  = in_ent;
              state_d = FULL;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              main_d  = skid_q;
              state_d = BUSY;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d = EMPTY;
        end
        in_rdy_d = (state_d != FULL);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q  <= EMPTY;
          main_q   <= '0;
          skid_q   <= '0;
          in_rdy_q <= 1'b1;
        end else begin
          state_q  <= state_d;
          main_q   <= main_d;
          skid_q   <= skid_d;
          in_rdy_q <= in_rdy_d;
        end
      end
    end else begin : g_reg
      logic vld_q, vld_d;
      logic in_xfer, out_xfer;

      assign out_valid = vld_q;
      assign in_ready  = !vld_q | out_ready;
      assign in_xfer   = in_valid & (!vld_q | out_ready);
      assign out_xfer  = vld_q & out_ready;

      always_comb begin
        vld_d  = vld_q;
        main_d = main_q;
        if (in_xfer) begin
          vld_d  = 1'b1;
          main_d = in_ent;
        end else if (out_xfer) begin
          vld_d = 1'b0;
        end
        if (flush) begin
          vld_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          main_q <= '0;
        end else begin
          vld_q  <= vld_d;
          main_q <= main_d;
        end
      end
    end
  endgenerate

  // Counters survive flush; only rst_n clears them.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (!out_valid && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  // A bubble must never carry a live write enable downstream.
  assign out_ctrl   = out_valid ? main_q.ctrl : '0;
  assign out_data   = main_q.data;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule
